cbsc_sn_tx: RTL and testbench
=============================

# cbsc_sn_tx

Transmit end of the CBSC stochastic link. It accepts binary operand pairs (x, w) over a valid/ready handshake and serialises each pair into one frame of 2^WIDTH cycles. Per cycle it emits a counter-based stochastic bit for x and a weight gate for w, with frame markers. Its outputs feed the lane counters of the CBSC MAC, replacing the free-running per-lane SNG and down counter with one framed, back-pressured source.

## Interface
- WIDTH, 7, operand width; frame length FRAME_LEN = 2^WIDTH cycles.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can take a pair this cycle.
- in_x  in  WIDTH  value to encode (ones density x/FRAME_LEN).
- in_w  in  WIDTH  weight; gate length in cycles.
- sn_valid  out  1  a frame bit is on sn_bit/sn_gate this cycle.
- sn_bit  out  1  stochastic bit of x.
- sn_gate  out  1  weight window: high for the first w bits of the frame.
- frame_start  out  1  pulse on the first bit of a frame.
- frame_last  out  1  pulse on the last bit (index FRAME_LEN-1).
- busy  out  1  frame in progress or pair held.

## Operation
- Storage: active register (x_a, w_a) drives the current frame. Holding register (x_h, w_h, hold_full) buffers one pending pair.
- in_ready = !hold_full && !rst. A transfer happens when in_valid && in_ready; the pair is written to the holding register.
- FSM states: IDLE, RUN.
  - IDLE: if hold_full, move the holding register to active, clear hold_full, set cnt = 0, go to RUN.
  - RUN: cnt increments each cycle. At cnt = FRAME_LEN-1 (wrap), if hold_full, load the next pair and stay in RUN with cnt = 0, giving back-to-back frames with no gap. Otherwise go to IDLE.
- A transfer in the same cycle as a load is legal: load and clear first, then write the new pair, so hold_full stays 1.
- Per-cycle outputs in RUN (registered, valid from the cycle after the state enters RUN):
  - ref = ref_map(cnt).
  - sn_bit = (ref < x_a).
  - sn_gate = (cnt < w_a).
  - sn_valid = 1.
  - frame_start = (cnt == 0).
  - frame_last = (cnt == FRAME_LEN-1).
- In IDLE: sn_valid, sn_bit, sn_gate, frame_start and frame_last are 0.
- Frame invariants:
  - Ones in sn_bit over a frame = x_a exactly.
  - Cycles with sn_gate high = w_a exactly.
  - x = 0 gives no ones. w = 0 gives the gate never high.
  - FRAME_LEN-1 is the maximum of each.
- Comparisons are unsigned WIDTH-bit. cnt is WIDTH bits and wraps naturally.
- busy = (state == RUN) || hold_full.

## Timing
- Reset: state IDLE, cnt 0, hold_full 0, and all outputs 0 (including in_ready while rst is high). in_ready is 1 on the first cycle after rst is released.
- Reset mid-frame aborts the frame: outputs are 0 on the next edge, and the pending pair is discarded.
- Latency: a pair accepted at edge t while IDLE gives frame_start/sn_valid at the output after edge t+2 (t+1 holding→active, t+2 registered outputs).
- Throughput: one pair per FRAME_LEN cycles when fed continuously. in_ready is low from acceptance of a second pending pair until the wrap that consumes it.
- in_x and in_w are sampled only on transfer. Changes at other times have no effect.

## Configuration
- CBSC_TX_BITREV_EN
  - Defined: ref_map(cnt) = bit-reverse of cnt over WIDTH bits (low-discrepancy). The gated product count over a frame, sum(sn_bit & sn_gate), ≈ x·w/FRAME_LEN.
  - Undefined: ref_map(cnt) = cnt (unary/thermometer stream). The gated product count = min(x, w).
- The frame invariants hold in both builds.

## Structure
- Shared package cbsc_pkg holds:
  - WIDTH default and the FRAME_LEN function.
  - The state enum {IDLE, RUN}.
  - The bit-reverse function.
- One sub-module, cbsc_ref_gen, contains the frame counter, the wrap/last flag and ref_map (the macro is applied here). The top contains the handshake, holding/active registers, FSM and output registers.

## Test plan
- Reset release, then x=64, w=64 → one 128-bit frame:
  - 64 sn_bit ones and 64 gate cycles.
  - Gated ones = 32 with the macro, 64 without.
  - frame_start on bit 0, frame_last on bit 127.
- Edge values: x=0, w=127 → 0 ones and 127 gate cycles. x=127, w=0 → 127 ones, gate never high.
- Back-to-back: offer three pairs continuously → in_ready drops after two are held, and frames are contiguous (frame_last followed immediately by frame_start). The third pair is accepted in the cycle of the first wrap.
- Handshake stall: hold in_valid high while in_ready is low and change in_x → the value captured is the one present on the accept cycle.
- Reset asserted at bit 50 with a pair pending → outputs 0 the next cycle, busy 0, no frame follows after release until a new transfer.
- Full-range sweep of x and w (bit-reverse build) → per-frame ones = x and gate count = w for all 128×128 combinations.

Source files
------------

// File: rtl/cbsc_pkg.sv
// Shared types and helpers for the CBSC stochastic link.
// Holds the default operand width, frame length and the bit-reverse map.
package cbsc_pkg;

  localparam int CBSC_WIDTH = 7;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int frame_len(input int w);
    return 1 << w;
  endfunction

  function automatic logic [31:0] bit_rev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cbsc_ref_gen.sv
// Frame counter, last-bit flag and reference map for the SN transmitter.
// CBSC_TX_BITREV_EN selects the bit-reversed (low-discrepancy) reference.
module cbsc_ref_gen
  import cbsc_pkg::*;
#(
  parameter int WIDTH = CBSC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] ref_val,
  output logic             last
);

  localparam logic [WIDTH-1:0] CNT_MAX =
    WIDTH'(frame_len(WIDTH) - 1);

  // Bit index within the frame; held at zero while idle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign last = (cnt == CNT_MAX);

`ifdef CBSC_TX_BITREV_EN
  assign ref_val = WIDTH'(bit_rev(32'(cnt), WIDTH));
`else
  assign ref_val = cnt;
`endif

endmodule

// File: rtl/cbsc_sn_tx.sv
// Transmit end of the CBSC link: framed, back-pressured SN source.
// Build option CBSC_TX_BITREV_EN selects bit-reversed reference order.
module cbsc_sn_tx
  import cbsc_pkg::*;
#(
  parameter int WIDTH = CBSC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_w,
  output logic             sn_valid,
  output logic             sn_bit,
  output logic             sn_gate,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] x_h;
  logic [WIDTH-1:0] w_h;
  logic             hold_full;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ref_val;
  logic             last;

  assign in_ready = !hold_full && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN) || hold_full;

  cbsc_ref_gen #(
    .WIDTH(WIDTH)
  ) u_ref (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .en     (state == RUN),
    .cnt    (cnt),
    .ref_val(ref_val),
    .last   (last)
  );

  // Next state and load strobe; a wrap with a pair held chains frames.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          if (hold_full) load = 1'b1;
          else state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Holding register; a write on a load cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      x_h       <= '0;
      w_h       <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      x_h       <= in_x;
      w_h       <= in_w;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Active register driving the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_a <= '0;
      w_a <= '0;
    end else if (load) begin
      x_a <= x_h;
      w_a <= w_h;
    end
  end

  // Registered per-bit outputs, all zero outside a frame.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      sn_valid    <= 1'b0;
      sn_bit      <= 1'b0;
      sn_gate     <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      sn_valid    <= 1'b1;
      sn_bit      <= (ref_val < x_a);
      sn_gate     <= (cnt < w_a);
      frame_start <= (cnt == '0);
      frame_last  <= last;
    end
  end

endmodule

// File: tb/tb_cbsc_sn_tx.sv
// Directed bench for cbsc_sn_tx: vector table plus multi-cycle sequences.
// Expected gated counts depend on whether CBSC_TX_BITREV_EN is defined.
module tb_cbsc_sn_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_x;
  logic [6:0] in_w;
  logic       sn_valid;
  logic       sn_bit;
  logic       sn_gate;
  logic       frame_start;
  logic       frame_last;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  cbsc_sn_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_w       (in_w),
    .sn_valid   (sn_valid),
    .sn_bit     (sn_bit),
    .sn_gate    (sn_gate),
    .frame_start(frame_start),
    .frame_last (frame_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] x;
    logic [6:0] w;
    int         gated_unary;
    int         gated_br;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer a pair and wait (bounded) for acceptance; returns at a negedge.
  task automatic send(input logic [6:0] x, input logic [6:0] w,
                      output int acc_cyc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Observe one frame starting at (or after) the current negedge.
  task automatic collect(input bit immediate,
                         output int ones, output int gates,
                         output int gated, output int marks_ok,
                         output int last_cyc);
    int n;
    ones = 0;
    gates = 0;
    gated = 0;
    marks_ok = 1;
    last_cyc = -1;
    if (!immediate) begin
      n = 0;
      while (!frame_start && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    if (!frame_start) begin
      marks_ok = 0;
      return;
    end
    for (int i = 0; i < 128; i++) begin
      if (!sn_valid) marks_ok = 0;
      if (frame_start != (i == 0)) marks_ok = 0;
      if (frame_last != (i == 127)) marks_ok = 0;
      if (i == 127) last_cyc = cyc;
      ones  += int'(sn_bit);
      gates += int'(sn_gate);
      gated += int'(sn_bit & sn_gate);
      @(negedge clk);
    end
  endtask

  function automatic int exp_gated(input vec_t v);
`ifdef CBSC_TX_BITREV_EN
    return v.gated_br;
`else
    return v.gated_unary;
`endif
  endfunction

  initial begin
    int a1, a2, a3;
    int o, g, gd, mk, lc, lc1;
    int n, seen;

    vt[0] = '{x: 7'd64,  w: 7'd64,  gated_unary: 64,  gated_br: 32};
    vt[1] = '{x: 7'd0,   w: 7'd127, gated_unary: 0,   gated_br: 0};
    vt[2] = '{x: 7'd127, w: 7'd0,   gated_unary: 0,   gated_br: 0};
    vt[3] = '{x: 7'd127, w: 7'd127, gated_unary: 127, gated_br: 127};
    vt[4] = '{x: 7'd1,   w: 7'd127, gated_unary: 1,   gated_br: 1};
    vt[5] = '{x: 7'd100, w: 7'd1,   gated_unary: 1,   gated_br: 1};
    vt[6] = '{x: 7'd32,  w: 7'd64,  gated_unary: 32,  gated_br: 16};
    vt[7] = '{x: 7'd5,   w: 7'd3,   gated_unary: 3,   gated_br: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    repeat (3) @(negedge clk);
    check("rst_sn_valid", int'(sn_valid), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].x, vt[i].w, a1);
      if (i == 0) begin
        check("lat_t0_valid", int'(sn_valid), 0);
        @(negedge clk);
        check("lat_t1_valid", int'(sn_valid), 0);
        @(negedge clk);
        check("lat_t2_start", int'(frame_start), 1);
      end
      collect(i == 0, o, g, gd, mk, lc);
      check($sformatf("v%0d_ones", i), o, int'(vt[i].x));
      check($sformatf("v%0d_gates", i), g, int'(vt[i].w));
      check($sformatf("v%0d_gated", i), gd, exp_gated(vt[i]));
      check($sformatf("v%0d_marks", i), mk, 1);
      check($sformatf("v%0d_idle", i), int'(busy), 0);
    end

    // Back-to-back: three pairs offered continuously.
    lc1 = -1;
    a3 = -1;
    fork
      begin
        send(7'd10, 7'd20, a1);
        check("b2b_ready_p1", int'(in_ready), 0);
        send(7'd127, 7'd127, a2);
        check("b2b_ready_drop", int'(in_ready), 0);
        send(7'd0, 7'd0, a3);
      end
      begin
        collect(1'b0, o, g, gd, mk, lc1);
        check("b2b_f1_ones", o, 10);
        check("b2b_f1_gates", g, 20);
        check("b2b_f1_marks", mk, 1);
        collect(1'b1, o, g, gd, mk, lc);
        check("b2b_f2_ones", o, 127);
        check("b2b_f2_gates", g, 127);
        check("b2b_f2_marks", mk, 1);
        collect(1'b1, o, g, gd, mk, lc);
        check("b2b_f3_ones", o, 0);
        check("b2b_f3_gates", g, 0);
        check("b2b_f3_marks", mk, 1);
      end
    join
    check("b2b_p3_accept", a3, lc1 + 1);

    // Stall: in_x changes while in_ready is low; accept-cycle value wins.
    fork
      begin
        send(7'd50, 7'd10, a1);
        send(7'd30, 7'd5, a2);
        in_valid = 1'b1;
        in_x = 7'd90;
        in_w = 7'd99;
        repeat (20) @(negedge clk);
        in_x = 7'd11;
        repeat (20) @(negedge clk);
        in_x = 7'd77;
        in_w = 7'd40;
        n = 0;
        while (!in_ready && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("stall_ready_seen", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_x = 7'd3;
        in_w = 7'd3;
      end
      begin
        collect(1'b0, o, g, gd, mk, lc);
        check("stall_f1_ones", o, 50);
        collect(1'b1, o, g, gd, mk, lc);
        check("stall_f2_ones", o, 30);
        collect(1'b1, o, g, gd, mk, lc);
        check("stall_f3_ones", o, 77);
        check("stall_f3_gates", g, 40);
        check("stall_f3_marks", mk, 1);
      end
    join

    // Reset at bit 50 with a pair pending.
    fork
      begin
        send(7'd60, 7'd60, a1);
        send(7'd20, 7'd20, a2);
      end
      begin
        n = 0;
        while (!frame_start && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("rst_mid_frame_seen", int'(frame_start), 1);
        repeat (50) @(negedge clk);
      end
    join
    check("rst_mid_pending", int'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", int'(sn_valid), 0);
    check("rst_mid_gate", int'(sn_gate), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", int'(in_ready), 1);
    seen = 0;
    repeat (300) begin
      seen += int'(sn_valid) + int'(busy);
      @(negedge clk);
    end
    check("rst_no_frame", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
